// File: rtl/capture_sequencer.sv
// Acquisition sequencer for one logic-analyser capture: programs the trigger
// delay stage, then drives sample-RAM writes through pre-fill, trigger wait and post-fill.
module capture_sequencer #(
  parameter int          ADDR_W  = 12,
  parameter logic [10:0] DLY_RST = 11'd100
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              cfg_we,
  input  logic [10:0]       cfg_delay,
  input  logic [ADDR_W-1:0] cfg_pre,
  input  logic [ADDR_W-1:0] cfg_post,
  input  logic              arm,
  input  logic              abort,
  input  logic              trig_in,
  output logic              ENTrig,
  output logic [7:0]        delayH,
  output logic [2:0]        delayL,
  output logic              setdelay,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_PRE   = 3'd3,
    S_WAIT  = 3'd4,
    S_POST  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t            state, nxt;
  logic              accept;
  logic [10:0]       dly_q;
  logic [ADDR_W-1:0] pre_q, post_q, cnt;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt    = state;
    accept = 1'b0;
    if (abort) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (arm) nxt = S_LOAD1;
        S_LOAD1:        nxt = S_LOAD2;
        S_LOAD2:        nxt = (pre_q != '0) ? S_PRE : S_WAIT;
        S_PRE:          if (cnt == pre_q - ADDR_W'(1)) nxt = S_WAIT;
        S_WAIT: begin
          // trig_in is only qualified here; PRE and LOAD* ignore it
          if (trig_in) begin
            accept = 1'b1;
            nxt    = (post_q != '0) ? S_POST : S_DONE;
          end
        end
        S_POST:         if (cnt == post_q - ADDR_W'(1)) nxt = S_DONE;
        default:        nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state decode so they flip with the state.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      dly_q     <= DLY_RST;
      pre_q     <= '0;
      post_q    <= '0;
      cnt       <= '0;
      ENTrig    <= 1'b0;
      delayH    <= '0;
      delayL    <= '0;
      setdelay  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      trig_addr <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (cfg_we && (state == S_IDLE || state == S_DONE)) begin
        dly_q  <= cfg_delay;
        pre_q  <= cfg_pre;
        post_q <= cfg_post;
      end
      ENTrig   <= (nxt == S_PRE) || (nxt == S_WAIT);
      wr_en    <= (nxt == S_PRE) || (nxt == S_WAIT) || (nxt == S_POST);
      busy     <= (nxt != S_IDLE) && (nxt != S_DONE);
      done     <= (nxt == S_DONE);
      setdelay <= (nxt == S_LOAD2);
      cnt      <= (state == S_PRE || state == S_POST) ? cnt + ADDR_W'(1) : '0;
      if (nxt == S_LOAD1) begin
        delayH    <= dly_q[10:3];
        delayL    <= dly_q[2:0];
        wr_addr   <= '0;
        trig_addr <= '0;
      end else begin
        if (wr_en)  wr_addr   <= wr_addr + ADDR_W'(1);
        if (accept) trig_addr <= wr_addr;
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: per-cycle vector table plus hand
// sequences for async reset, cfg_we in POST and address wrap on a narrow instance.
module tb_capture_sequencer;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic        cfg_we, arm, abort, trig_in;
  logic [10:0] cfg_delay;
  logic [11:0] cfg_pre, cfg_post;
  logic        ENTrig, setdelay, wr_en, busy, done;
  logic [7:0]  delayH;
  logic [2:0]  delayL;
  logic [11:0] wr_addr, trig_addr;

  capture_sequencer #(.ADDR_W(12), .DLY_RST(11'd100)) dut (
    .CLK(CLK), .RSTn(RSTn), .cfg_we(cfg_we), .cfg_delay(cfg_delay),
    .cfg_pre(cfg_pre), .cfg_post(cfg_post), .arm(arm), .abort(abort),
    .trig_in(trig_in), .ENTrig(ENTrig), .delayH(delayH), .delayL(delayL),
    .setdelay(setdelay), .wr_en(wr_en), .wr_addr(wr_addr),
    .trig_addr(trig_addr), .busy(busy), .done(done));

  logic        s_cfg_we, s_arm, s_abort, s_trig;
  logic [10:0] s_cfg_delay;
  logic [3:0]  s_cfg_pre, s_cfg_post;
  logic        s_ENTrig, s_setdelay, s_wr_en, s_busy, s_done;
  logic [7:0]  s_delayH;
  logic [2:0]  s_delayL;
  logic [3:0]  s_wr_addr, s_trig_addr;

  capture_sequencer #(.ADDR_W(4), .DLY_RST(11'd100)) dut_s (
    .CLK(CLK), .RSTn(RSTn), .cfg_we(s_cfg_we), .cfg_delay(s_cfg_delay),
    .cfg_pre(s_cfg_pre), .cfg_post(s_cfg_post), .arm(s_arm), .abort(s_abort),
    .trig_in(s_trig), .ENTrig(s_ENTrig), .delayH(s_delayH), .delayL(s_delayL),
    .setdelay(s_setdelay), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .trig_addr(s_trig_addr), .busy(s_busy), .done(s_done));

  // {ENTrig,setdelay,wr_en,busy,done} per state
  localparam logic [4:0] F_IDLE = 5'b00000, F_L1 = 5'b00010, F_L2 = 5'b01010,
                         F_PW = 5'b10110, F_PO = 5'b00110, F_DN = 5'b00001;

  logic [39:0] obs;
  assign obs = {ENTrig, setdelay, wr_en, busy, done, wr_addr, trig_addr, delayH, delayL};

  typedef struct {
    logic        we, arm, ab, tr;
    logic [10:0] dly;
    logic [11:0] pre, post;
    logic [39:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] cd;
  logic [11:0] cp, cq;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [39:0] e(logic [4:0] f, int wa, int ta, logic [10:0] d);
    return {f, 12'(wa), 12'(ta), d};
  endfunction

  task automatic add(logic we, logic a, logic ab, logic tr, logic [39:0] ex);
    tbl.push_back('{we, a, ab, tr, cd, cp, cq, ex});
  endtask

  task automatic chk(string nm, logic [39:0] act, logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step(logic we, logic a, logic ab, logic tr);
    @(negedge CLK);
    cfg_we = we; arm = a; abort = ab; trig_in = tr;
    @(posedge CLK);
    #1;
  endtask

  task automatic sstep(logic we, logic a);
    @(negedge CLK);
    s_cfg_we = we; s_arm = a;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    cfg_we = 0; arm = 0; abort = 0; trig_in = 0;
    cfg_delay = '0; cfg_pre = '0; cfg_post = '0;
    s_cfg_we = 0; s_arm = 0; s_abort = 0; s_trig = 0;
    s_cfg_delay = '0; s_cfg_pre = '0; s_cfg_post = '0;

    // delay 0x123, pre 4, post 3, trigger on 10th WAIT cycle; arm/trig in PRE ignored
    cd = 11'h123; cp = 4; cq = 3;
    add(1, 0, 0, 0, e(F_IDLE, 0, 0, 0));
    add(0, 1, 0, 0, e(F_L1, 0, 0, 11'h123));
    add(0, 0, 0, 0, e(F_L2, 0, 0, 11'h123));
    for (int i = 0; i < 4; i++) add(0, i == 2, 0, i == 1, e(F_PW, i, 0, 11'h123));
    for (int a = 4; a < 14; a++) add(0, 0, 0, 0, e(F_PW, a, 0, 11'h123));
    add(0, 0, 0, 1, e(F_PO, 14, 13, 11'h123));
    add(0, 0, 0, 0, e(F_PO, 15, 13, 11'h123));
    add(0, 0, 0, 0, e(F_PO, 16, 13, 11'h123));
    add(0, 0, 0, 0, e(F_DN, 17, 13, 11'h123));
    add(0, 0, 0, 0, e(F_DN, 17, 13, 11'h123));
    // pre 0, post 0, trig held high: single WAIT write at 0
    cd = 11'h0A5; cp = 0; cq = 0;
    add(1, 0, 0, 0, e(F_DN, 17, 13, 11'h123));
    add(0, 1, 0, 1, e(F_L1, 0, 0, 11'h0A5));
    add(0, 0, 0, 1, e(F_L2, 0, 0, 11'h0A5));
    add(0, 0, 0, 1, e(F_PW, 0, 0, 11'h0A5));
    add(0, 0, 0, 1, e(F_DN, 1, 0, 11'h0A5));
    // abort together with trig in WAIT
    cd = 11'h3C1; cp = 2; cq = 2;
    add(1, 0, 0, 0, e(F_DN, 1, 0, 11'h0A5));
    add(0, 1, 0, 0, e(F_L1, 0, 0, 11'h3C1));
    add(0, 0, 0, 0, e(F_L2, 0, 0, 11'h3C1));
    for (int a = 0; a < 4; a++) add(0, 0, 0, 0, e(F_PW, a, 0, 11'h3C1));
    add(0, 0, 1, 1, e(F_IDLE, 4, 0, 11'h3C1));
    add(0, 0, 0, 1, e(F_IDLE, 4, 0, 11'h3C1));

    #2;
    chk("reset_main", obs, 40'h0);
    chk("reset_small", {s_ENTrig, s_setdelay, s_wr_en, s_busy, s_done, s_wr_addr, s_trig_addr, s_delayH, s_delayL}, 40'h0);
    @(negedge CLK);
    RSTn = 1'b1;

    foreach (tbl[k]) begin
      cfg_delay = tbl[k].dly; cfg_pre = tbl[k].pre; cfg_post = tbl[k].post;
      step(tbl[k].we, tbl[k].arm, tbl[k].ab, tbl[k].tr);
      chk($sformatf("vec%0d", k), obs, tbl[k].exp);
    end

    // cfg_we during POST must not shorten the run; then async reset in POST
    cfg_delay = 11'h3C1; cfg_pre = 0; cfg_post = 3;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("p6_wait", obs, e(F_PW, 0, 0, 11'h3C1));
    step(0, 0, 0, 1);
    chk("p6_post0", obs, e(F_PO, 1, 0, 11'h3C1));
    cfg_post = 1;
    step(1, 0, 0, 0);
    chk("p6_cfg_ignored", obs, e(F_PO, 2, 0, 11'h3C1));
    step(0, 0, 0, 0);
    chk("p6_post2", obs, e(F_PO, 3, 0, 11'h3C1));
    #2 RSTn = 1'b0;
    #1 chk("async_reset", obs, 40'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    step(0, 1, 0, 0);
    chk("shadow_dly_rst", obs, e(F_L1, 0, 0, 11'd100));
    step(0, 0, 1, 0);
    chk("abort_load", obs, e(F_IDLE, 0, 0, 11'd100));

    // narrow instance: pre 15 with trig high throughout, addresses wrap
    s_cfg_pre = 4'd15; s_cfg_post = 4'd3; s_cfg_delay = 11'h001; s_trig = 1'b1;
    sstep(1, 0);
    sstep(0, 1);
    sstep(0, 0);
    for (int i = 0; i < 15; i++) begin
      sstep(0, 0);
      chk($sformatf("wrap_pre%0d", i), 40'({s_ENTrig, s_wr_en, s_busy, s_wr_addr}), 40'({3'b111, 4'(i)}));
    end
    sstep(0, 0);
    chk("wrap_wait", 40'({s_ENTrig, s_wr_en, s_wr_addr, s_trig_addr}), 40'({2'b11, 4'd15, 4'd0}));
    for (int i = 0; i < 3; i++) begin
      sstep(0, 0);
      chk($sformatf("wrap_post%0d", i), 40'({s_ENTrig, s_wr_en, s_wr_addr, s_trig_addr}), 40'({2'b01, 4'(i), 4'd15}));
    end
    sstep(0, 0);
    chk("wrap_done", 40'({s_done, s_wr_en, s_busy, s_wr_addr, s_trig_addr}), 40'({3'b100, 4'd3, 4'd15}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
